conv_sequencer: RTL and testbench

CONV_SEQUENCER -- requirements
Module: conv_sequencer

---
 rtl/conv_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_conv_sequencer.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sequencer.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : conv_sequencer
//  Purpose  : Job sequencer for a 3x3 convolution datapath over a 28x28 image.
//             It loads a 9-tap signed kernel, replays it into the datapath, and
//             streams OUT_W*OUT_W windows into it. A valid-tag chain matches the
//             datapath latency, so each result comes out tagged with its
//             row/column position.
//  Ports    : clk, resetn            - clock, async active-low reset
//             start, keep_w          - job request / reuse the loaded kernel
//             busy, done             - job in progress / one-cycle completion
//             wt_valid/data/ready    - kernel stream, k0..k8 row-major
//             win_valid/data/ready   - 3x3 window stream, byte n = pixel n
//             conv_i_data            - registered window to the datapath
//             conv_w_req/w_data      - kernel replay to the datapath
//             conv_o_data            - datapath result (PIPE_LAT stages later)
//             out_valid/data/row/col/last - tagged result stream, no backpressure
//  Revision : 1.0 - initial release
// ============================================================================
module conv_sequencer #(
   parameter int OUT_W    = 26,
   parameter int PIPE_LAT = 5
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic               keep_w,
   output logic               busy,
   output logic               done,
   input  logic               wt_valid,
   input  logic signed [7:0]  wt_data,
   output logic               wt_ready,
   input  logic               win_valid,
   input  logic [71:0]        win_data,
   output logic               win_ready,
   output logic [71:0]        conv_i_data,
   output logic [7:0]         conv_w_data,
   output logic               conv_w_req,
   input  logic signed [19:0] conv_o_data,
   output logic               out_valid,
   output logic signed [19:0] out_data,
   output logic [4:0]         out_row,
   output logic [4:0]         out_col,
   output logic               out_last
);

   localparam int                 c_N_WIN    = OUT_W * OUT_W;
   localparam int                 c_CNT_W    = $clog2(c_N_WIN + 1);
   localparam logic [4:0]         c_EDGE     = 5'(OUT_W - 1);
   localparam logic [3:0]         c_K_LAST   = 4'd8;
   localparam logic [3:0]         c_K_NUM    = 4'd9;
   localparam logic [c_CNT_W-1:0] c_WIN_LAST = c_CNT_W'(c_N_WIN - 1);
   localparam logic [c_CNT_W-1:0] c_WIN_ALL  = c_CNT_W'(c_N_WIN);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_W = 3'd1,
      S_PUSH_W = 3'd2,
      S_RUN    = 3'd3,
      S_DRAIN  = 3'd4,
      S_FIN    = 3'd5
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [3:0]          r_wcnt;
   logic [3:0]          r_pcnt;
   logic signed [7:0]   r_wbuf [9];
   logic                r_w_loaded;
   logic [c_CNT_W-1:0]  r_wincnt;
   logic [PIPE_LAT:0]   r_tag;
   logic [4:0]          r_row;
   logic [4:0]          r_col;

   logic                w_job_start;
   logic                w_reuse;
   logic                w_wt_acc;
   logic                w_win_acc;
   logic                w_win_room;
   logic                w_push_end;

   assign w_job_start = (r_state == S_IDLE) && start;
   assign w_reuse     = keep_w && r_w_loaded;
   assign w_wt_acc    = wt_valid && wt_ready;
   assign w_win_acc   = win_valid && win_ready;
   assign w_win_room  = (r_wincnt < c_WIN_ALL);
   // Cycle after the 9th replay beat: request is low, kernel is now resident.
   assign w_push_end  = (r_state == S_PUSH_W) && (r_pcnt == c_K_NUM);

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ------------------------------------------------------------------------
   // Next state and state-decoded outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_next     = r_state;
      busy       = 1'b1;
      done       = 1'b0;
      wt_ready   = 1'b0;
      win_ready  = 1'b0;
      conv_w_req = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               w_next = w_reuse ? S_RUN : S_LOAD_W;
            end
         end
         S_LOAD_W: begin
            wt_ready = 1'b1;
            if (wt_valid && (r_wcnt == c_K_LAST)) begin
               w_next = S_PUSH_W;
            end
         end
         S_PUSH_W: begin
            conv_w_req = (r_pcnt < c_K_NUM);
            if (r_pcnt == c_K_NUM) begin
               w_next = S_RUN;
            end
         end
         S_RUN: begin
            win_ready = w_win_room;
            if (win_valid && w_win_room && (r_wincnt == c_WIN_LAST)) begin
               w_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Nothing enters the chain here, so when only the top tag (or
            // nothing) remains, the chain is empty after this edge. Leaving
            // now puts done exactly one cycle after the final result.
            if (r_tag[PIPE_LAT-1:0] == '0) begin
               w_next = S_FIN;
            end
         end
         S_FIN: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Kernel buffer, counters, window register, valid-tag chain
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wcnt      <= '0;
         r_pcnt      <= '0;
         r_w_loaded  <= 1'b0;
         r_wincnt    <= '0;
         r_tag       <= '0;
         r_row       <= '0;
         r_col       <= '0;
         conv_i_data <= '0;
         for (int i = 0; i < 9; i++) begin
            r_wbuf[i] <= '0;
         end
      end else begin
         if (w_job_start) begin
            r_wcnt <= '0;
         end else if (w_wt_acc) begin
            r_wbuf[r_wcnt] <= wt_data;
            r_wcnt         <= (r_wcnt == c_K_LAST) ? 4'd0 : r_wcnt + 4'd1;
         end

         if (r_state == S_PUSH_W) begin
            r_pcnt <= r_pcnt + 4'd1;
         end else begin
            r_pcnt <= '0;
         end

         // A fresh load invalidates the old kernel until replay completes.
         if (w_job_start && !w_reuse) begin
            r_w_loaded <= 1'b0;
         end else if (w_push_end) begin
            r_w_loaded <= 1'b1;
         end

         if (w_job_start) begin
            r_wincnt <= '0;
         end else if (w_win_acc) begin
            r_wincnt <= r_wincnt + 1'b1;
         end

         if (w_win_acc) begin
            conv_i_data <= win_data;
         end

         r_tag <= {r_tag[PIPE_LAT-1:0], w_win_acc};

         if (w_job_start) begin
            r_row <= '0;
            r_col <= '0;
         end else if (out_valid) begin
            if (r_col == c_EDGE) begin
               r_col <= '0;
               r_row <= (r_row == c_EDGE) ? 5'd0 : r_row + 5'd1;
            end else begin
               r_col <= r_col + 5'd1;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Output stream
   // ------------------------------------------------------------------------
   assign out_valid   = r_tag[PIPE_LAT];
   assign out_data    = out_valid ? conv_o_data : '0;
   assign out_row     = r_row;
   assign out_col     = r_col;
   assign out_last    = out_valid && (r_row == c_EDGE) && (r_col == c_EDGE);
   assign conv_w_data = conv_w_req ? r_wbuf[r_pcnt] : '0;

endmodule
`default_nettype wire

// File: tb/tb_conv_sequencer.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : tb_conv_sequencer
//  Purpose  : Self-checking bench for conv_sequencer with a behavioural
//             convolution datapath and a result scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_sequencer;

   localparam int OUT_W    = 26;
   localparam int PIPE_LAT = 5;
   localparam int N_WIN    = OUT_W * OUT_W;

   logic               clk       = 1'b0;
   logic               resetn    = 1'b0;
   logic               start     = 1'b0;
   logic               keep_w    = 1'b0;
   logic               wt_valid  = 1'b0;
   logic signed [7:0]  wt_data   = '0;
   logic               win_valid = 1'b0;
   logic [71:0]        win_data  = '0;
   logic               busy, done, wt_ready, win_ready, conv_w_req;
   logic               out_valid, out_last;
   logic [71:0]        conv_i_data;
   logic [7:0]         conv_w_data;
   logic signed [19:0] conv_o_data;
   logic signed [19:0] out_data;
   logic [4:0]         out_row, out_col;

   int n_cmp    = 0;
   int n_err    = 0;
   int cyc      = 0;
   int n_out    = 0;
   int n_done   = 0;
   int n_req    = 0;
   int last_cyc = -10;
   int req_prev = -10;
   int sb_k     = 0;
   bit req_gap  = 1'b0;
   int kern [9];
   logic [7:0] wq_obs [$];

   typedef struct {
      logic signed [19:0] data;
      logic [4:0]         row;
      logic [4:0]         col;
      logic               last;
      int                 cyc;
   } exp_t;
   exp_t exp_q [$];

   conv_sequencer #(.OUT_W(OUT_W), .PIPE_LAT(PIPE_LAT)) dut (
      .clk(clk), .resetn(resetn), .start(start), .keep_w(keep_w),
      .busy(busy), .done(done),
      .wt_valid(wt_valid), .wt_data(wt_data), .wt_ready(wt_ready),
      .win_valid(win_valid), .win_data(win_data), .win_ready(win_ready),
      .conv_i_data(conv_i_data), .conv_w_data(conv_w_data), .conv_w_req(conv_w_req),
      .conv_o_data(conv_o_data),
      .out_valid(out_valid), .out_data(out_data), .out_row(out_row),
      .out_col(out_col), .out_last(out_last)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- behavioural datapath (shares resetn) ----------------
   logic signed [7:0]  dw [9];
   int                 dwi;
   logic signed [19:0] dp [PIPE_LAT];

   function automatic logic signed [19:0] dp_dot(input logic [71:0] d);
      int s = 0;
      for (int n = 0; n < 9; n++) s += int'($signed(d[8*n +: 8])) * int'(dw[n]);
      return 20'(s);
   endfunction

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dwi <= 0;
         for (int i = 0; i < 9; i++) dw[i] <= '0;
         for (int i = 0; i < PIPE_LAT; i++) dp[i] <= '0;
      end else begin
         if (conv_w_req) begin
            if (dwi < 9) dw[dwi] <= conv_w_data;
            dwi <= dwi + 1;
         end else begin
            dwi <= 0;
         end
         dp[0] <= dp_dot(conv_i_data);
         for (int i = 1; i < PIPE_LAT; i++) dp[i] <= dp[i-1];
      end
   end
   assign conv_o_data = dp[PIPE_LAT-1];

   // ---------------- reference and stimulus helpers ----------------
   function automatic logic signed [19:0] conv_ref(input logic [71:0] d);
      int s = 0;
      for (int n = 0; n < 9; n++) s += int'($signed(d[8*n +: 8])) * kern[n];
      return 20'(s);
   endfunction

   function automatic logic [71:0] mkwin(input int mode);
      logic [71:0] w;
      for (int n = 0; n < 9; n++) begin
         if (mode == 0) w[8*n +: 8] = 8'd1;
         else           w[8*n +: 8] = 8'($urandom);
      end
      if (mode == 1) w[39:32] = 8'd127;
      return w;
   endfunction

   // ---------------- scoreboard / monitor ----------------
   always @(negedge clk) begin
      exp_t e;
      if (!resetn) begin
         exp_q.delete();
      end else begin
         if (out_valid) begin
            n_out++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL out_unexpected: got data=%0d row=%0d col=%0d, required no output",
                        out_data, out_row, out_col);
            end else begin
               e = exp_q.pop_front();
               if (out_data !== e.data || out_row !== e.row || out_col !== e.col ||
                   out_last !== e.last || (cyc - e.cyc) != PIPE_LAT + 1) begin
                  n_err++;
                  $display("FAIL out_item: got data=%0d row=%0d col=%0d last=%0b lat=%0d, required data=%0d row=%0d col=%0d last=%0b lat=%0d",
                           out_data, out_row, out_col, out_last, cyc - e.cyc,
                           e.data, e.row, e.col, e.last, PIPE_LAT + 1);
               end
            end
            if (out_last) last_cyc = cyc;
         end
         if (done) begin
            n_done++;
            n_cmp++;
            if (cyc != last_cyc + 1) begin
               n_err++;
               $display("FAIL done_timing: done at cycle %0d, required %0d", cyc, last_cyc + 1);
            end
         end
         if (win_valid && win_ready) begin
            e.data = conv_ref(win_data);
            e.row  = 5'(sb_k / OUT_W);
            e.col  = 5'(sb_k % OUT_W);
            e.last = (sb_k == N_WIN - 1);
            e.cyc  = cyc;
            exp_q.push_back(e);
            sb_k++;
         end
         if (conv_w_req) begin
            if (wq_obs.size() > 0 && req_prev != cyc - 1) req_gap = 1'b1;
            wq_obs.push_back(conv_w_data);
            req_prev = cyc;
            n_req++;
         end
      end
   end

   // ---------------- stimulus tasks ----------------
   task automatic start_job(input bit keep);
      @(posedge clk); #1;
      start = 1'b1; keep_w = keep; sb_k = 0;
      @(posedge clk); #1;
      start = 1'b0; keep_w = 1'b0;
   endtask

   task automatic feed_weights(input bit gap4);
      for (int i = 0; i < 9; i++) begin
         bit a = 1'b0;
         int t = 0;
         wt_valid = 1'b1;
         wt_data  = 8'(kern[i]);
         while (!a && t < 50) begin
            @(negedge clk); a = wt_ready;
            @(posedge clk); #1; t++;
         end
         if (!a) begin
            n_cmp++; n_err++;
            $display("FAIL wt_accept_timeout: weight %0d wt_ready=%0b required 1", i, wt_ready);
         end
         if (gap4 && i == 4) begin
            wt_valid = 1'b0;
            repeat (3) begin @(posedge clk); #1; end
         end
      end
      wt_valid = 1'b0;
   endtask

   task automatic feed_windows(input int mode, input int gap_pct, input int stop_at,
                               input bit poke_start);
      int idx = 0;
      int t   = 0;
      bit a;
      win_data = mkwin(mode);
      while (idx < stop_at && t < 20000) begin
         win_valid = (int'($urandom_range(99)) >= gap_pct);
         if (poke_start) begin
            start  = ($urandom_range(19) == 0);
            keep_w = 1'($urandom_range(1));
         end
         @(negedge clk); a = win_valid && win_ready;
         @(posedge clk); #1; t++;
         if (a) begin idx++; win_data = mkwin(mode); end
      end
      win_valid = 1'b0; start = 1'b0; keep_w = 1'b0;
      if (idx < stop_at) begin
         n_cmp++; n_err++;
         $display("FAIL win_accept_timeout: accepted %0d windows, required %0d", idx, stop_at);
      end
   endtask

   task automatic wait_done(output bit got);
      got = 1'b0;
      for (int t = 0; t < 200 && !got; t++) begin
         @(negedge clk);
         if (done) got = 1'b1;
      end
      @(posedge clk); #1;
   endtask

   // ---------------- scenario tasks ----------------
   task automatic test_reset();
      resetn = 1'b0; start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({busy, done, wt_ready, win_ready, conv_w_req, out_valid, out_last} !== 7'b0) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b, required 0000000",
                  {busy, done, wt_ready, win_ready, conv_w_req, out_valid, out_last});
      end
      n_cmp++;
      if (conv_i_data !== '0) begin n_err++; $display("FAIL reset_conv_i_data: got %h required 0", conv_i_data); end
      n_cmp++;
      if (conv_w_data !== '0) begin n_err++; $display("FAIL reset_conv_w_data: got %h required 0", conv_w_data); end
      n_cmp++;
      if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %0d required 0", out_data); end
      n_cmp++;
      if (out_row !== '0 || out_col !== '0) begin
         n_err++; $display("FAIL reset_rowcol: got %0d/%0d required 0/0", out_row, out_col);
      end
      start  = 1'b0;
      resetn = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset_release_busy: got %0b required 0", busy); end
   endtask

   task automatic check_job(input string name, input int o0, input int d0);
      n_cmp++;
      if (n_out - o0 != N_WIN) begin
         n_err++; $display("FAIL %s_count: got %0d outputs required %0d", name, n_out - o0, N_WIN);
      end
      n_cmp++;
      if (n_done - d0 != 1) begin
         n_err++; $display("FAIL %s_dones: got %0d required 1", name, n_done - d0);
      end
   endtask

   task automatic test_kernel_push();
      int o0, d0; bit got;
      for (int i = 0; i < 9; i++) kern[i] = i + 1;
      wq_obs.delete(); req_gap = 1'b0;
      o0 = n_out; d0 = n_done;
      start_job(1'b1);   // keep_w with nothing loaded must still load
      n_cmp++;
      if (wt_ready !== 1'b1 || busy !== 1'b1) begin
         n_err++; $display("FAIL keep_after_reset_load: wt_ready=%0b busy=%0b required 1/1", wt_ready, busy);
      end
      feed_weights(1'b1);
      repeat (12) begin @(posedge clk); #1; end
      n_cmp++;
      if (wq_obs.size() != 9) begin
         n_err++; $display("FAIL push_len: got %0d req cycles required 9", wq_obs.size());
      end
      for (int i = 0; i < 9; i++) begin
         n_cmp++;
         if (i >= wq_obs.size() || wq_obs[i] !== 8'(i + 1)) begin
            n_err++; $display("FAIL push_val_%0d: got %0d required %0d", i,
                              (i < wq_obs.size()) ? wq_obs[i] : 8'hxx, i + 1);
         end
      end
      n_cmp++;
      if (req_gap !== 1'b0) begin n_err++; $display("FAIL push_contiguous: gap=%0b required 0", req_gap); end
      n_cmp++;
      if (conv_w_req !== 1'b0 || wt_ready !== 1'b0 || win_ready !== 1'b1) begin
         n_err++; $display("FAIL push_to_run: req=%0b wt_ready=%0b win_ready=%0b required 0/0/1",
                           conv_w_req, wt_ready, win_ready);
      end
      feed_windows(2, 0, N_WIN, 1'b0);
      wait_done(got);
      n_cmp++;
      if (!got) begin n_err++; $display("FAIL push_job_done: done=0 required 1"); end
      check_job("push_job", o0, d0);
   endtask

   task automatic test_all_ones();
      int o0, d0; bit got;
      for (int i = 0; i < 9; i++) kern[i] = 1;
      o0 = n_out; d0 = n_done;
      start_job(1'b0);
      n_cmp++;
      if (wt_ready !== 1'b1) begin n_err++; $display("FAIL ones_load: wt_ready=%0b required 1", wt_ready); end
      feed_weights(1'b0);
      feed_windows(0, 0, N_WIN, 1'b0);
      wait_done(got);
      n_cmp++;
      if (!got) begin n_err++; $display("FAIL ones_done: done=0 required 1"); end
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL ones_idle: busy=%0b required 0", busy); end
      check_job("ones", o0, d0);
   endtask

   task automatic test_keep_w();
      int o0, d0, r0; bit got;
      o0 = n_out; d0 = n_done; r0 = n_req;
      start_job(1'b1);
      n_cmp++;
      if (wt_ready !== 1'b0 || win_ready !== 1'b1 || busy !== 1'b1) begin
         n_err++; $display("FAIL keep_run: wt_ready=%0b win_ready=%0b busy=%0b required 0/1/1",
                           wt_ready, win_ready, busy);
      end
      feed_windows(2, 10, N_WIN, 1'b0);
      wait_done(got);
      n_cmp++;
      if (!got) begin n_err++; $display("FAIL keep_done: done=0 required 1"); end
      n_cmp++;
      if (n_req != r0) begin n_err++; $display("FAIL keep_no_push: got %0d req cycles required 0", n_req - r0); end
      check_job("keep", o0, d0);
   endtask

   task automatic test_center_gaps();
      int o0, d0; bit got;
      for (int i = 0; i < 9; i++) kern[i] = 0;
      kern[4] = -2;
      o0 = n_out; d0 = n_done;
      start_job(1'b0);
      feed_weights(1'b0);
      feed_windows(1, 35, N_WIN, 1'b0);
      wait_done(got);
      n_cmp++;
      if (!got) begin n_err++; $display("FAIL center_done: done=0 required 1"); end
      check_job("center", o0, d0);
   endtask

   task automatic test_start_ignored();
      int o0, d0; bit got; bit stray = 1'b0;
      o0 = n_out; d0 = n_done;
      start_job(1'b1);
      feed_windows(2, 20, N_WIN, 1'b1);
      wait_done(got);
      n_cmp++;
      if (!got) begin n_err++; $display("FAIL poke_done: done=0 required 1"); end
      for (int t = 0; t < 10; t++) begin
         @(posedge clk); #1;
         if (busy !== 1'b0) stray = 1'b1;
      end
      n_cmp++;
      if (stray) begin n_err++; $display("FAIL poke_idle: busy seen 1 after done, required 0"); end
      check_job("poke", o0, d0);
   endtask

   task automatic test_reset_mid();
      int o0, d0; bit got; bit stray = 1'b0;
      start_job(1'b1);
      feed_windows(2, 0, 300, 1'b0);
      #2 resetn = 1'b0;
      #1;
      n_cmp++;
      if ({busy, done, wt_ready, win_ready, conv_w_req, out_valid, out_last} !== 7'b0 ||
          conv_i_data !== '0 || conv_w_data !== '0) begin
         n_err++; $display("FAIL midreset_outputs: ctrl=%b i_data=%h w_data=%h required all 0",
                           {busy, done, wt_ready, win_ready, conv_w_req, out_valid, out_last},
                           conv_i_data, conv_w_data);
      end
      o0 = n_out; d0 = n_done;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      for (int t = 0; t < 20; t++) begin
         @(posedge clk); #1;
         if (busy !== 1'b0 || out_valid !== 1'b0) stray = 1'b1;
      end
      n_cmp++;
      if (stray || n_out != o0 || n_done != d0) begin
         n_err++; $display("FAIL midreset_quiet: outputs=%0d dones=%0d busy_seen=%0b required 0/0/0",
                           n_out - o0, n_done - d0, stray);
      end
      o0 = n_out; d0 = n_done;
      start_job(1'b1);   // kernel discarded by reset: must reload
      n_cmp++;
      if (wt_ready !== 1'b1) begin n_err++; $display("FAIL midreset_reload: wt_ready=%0b required 1", wt_ready); end
      feed_weights(1'b0);
      feed_windows(2, 15, N_WIN, 1'b0);
      wait_done(got);
      n_cmp++;
      if (!got) begin n_err++; $display("FAIL midreset_done: done=0 required 1"); end
      check_job("midreset", o0, d0);
   endtask

   initial begin
      test_reset();
      test_kernel_push();
      test_all_ones();
      test_keep_w();
      test_center_gaps();
      test_start_ignored();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
